// File: rtl/rw_sched_pkg.sv
// Shared types for the rw_sched request scheduler: FSM state and operation type.
package rw_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/rw_sched_rr_arb.sv
// NCH-way round-robin arbiter; the pointer moves to one past the grant when adv_i is strobed.
module rw_sched_rr_arb
  import rw_sched_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_i,
  input  logic           adv_i,
  output logic [CHW-1:0] gnt_idx_o,
  output logic           gnt_any_o
);

  logic [CHW-1:0] ptr_q;
  logic [CHW-1:0] lo_idx, hi_idx;
  logic           lo_any, hi_any;

  // Descending scan: the last hit is the lowest index, overall and at/after the pointer.
  always_comb begin
    lo_idx = '0;
    lo_any = 1'b0;
    hi_idx = '0;
    hi_any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = CHW'(i);
        lo_any = 1'b1;
        if (CHW'(i) >= ptr_q) begin
          hi_idx = CHW'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign gnt_idx_o = hi_any ? hi_idx : lo_idx;
  assign gnt_any_o = lo_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= (gnt_idx_o == CHW'(NCH - 1)) ? '0 : gnt_idx_o + CHW'(1);
    end
  end

endmodule

// File: rtl/rw_sched.sv
// Round-robin read/write scheduler with a per-request deadline of MAX_LAT cycles.
// Define RW_SCHED_STICKY_IRQ_EN to make interrupt bits sticky until irq_clr.
module rw_sched
  import rw_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int MAX_LAT = 5,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] read,
  input  logic [NCH-1:0] write,
  output logic [NCH-1:0] rd_served,
  output logic [NCH-1:0] wr_served,
  output logic [NCH-1:0] interrupt,
  input  logic [NCH-1:0] irq_clr,
  output logic           proto_err,
  output logic           op_valid,
  input  logic           op_ready,
  output logic           op_write,
  output logic [CHW-1:0] op_ch,
  input  logic           op_done,
  output logic           op_abort
);

  localparam int AGEW = $clog2(MAX_LAT + 1);
  // Timing out as age becomes MAX_LAT-1 keeps every request resolved within MAX_LAT cycles.
  localparam logic [AGEW-1:0] TO_AGE = AGEW'(MAX_LAT - 2);

  logic [NCH-1:0]  read_q, write_q;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [AGEW-1:0] age_q [NCH];
  logic [AGEW-1:0] age_d [NCH];
  op_e             op_q  [NCH];
  op_e             op_d  [NCH];
  logic [NCH-1:0]  irq_q, irq_d;
  logic            proto_err_q, proto_err_d;

  state_e          state_q;
  logic [CHW-1:0]  ch_q;
  logic            op_valid_q, op_write_q, op_abort_q;
  logic [NCH-1:0]  rd_served_q, wr_served_q;

  logic [NCH-1:0]  both, rise, wr_rise, cap, cur_oh, done_vec, to_hit, to_fire, arb_req;
  logic [CHW-1:0]  arb_idx;
  logic            arb_any, arb_adv;

  assign both     = read & write;
  assign wr_rise  = write & ~write_q;
  assign rise     = (read & ~read_q) | wr_rise;
  assign cap      = rise & ~both & ~pend_q;
  assign cur_oh   = NCH'(1) << ch_q;
  assign done_vec = (state_q == WAIT && op_done) ? cur_oh : '0;
  assign to_fire  = to_hit & ~done_vec;

  always_comb begin
    to_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      to_hit[i] = pend_q[i] && (age_q[i] == TO_AGE);
    end
  end

  always_comb begin
    pend_d      = (pend_q & ~to_hit & ~done_vec) | cap;
    proto_err_d = (|both) | (|(rise & pend_q));
    for (int i = 0; i < NCH; i++) begin
      age_d[i] = age_q[i];
      op_d[i]  = op_q[i];
      if (cap[i]) begin
        age_d[i] = '0;
        op_d[i]  = wr_rise[i] ? OP_WR : OP_RD;
      end else if (pend_q[i]) begin
        age_d[i] = age_q[i] + AGEW'(1);
      end
    end
  end

`ifdef RW_SCHED_STICKY_IRQ_EN
  assign irq_d = to_fire | (irq_q & ~irq_clr);
`else
  logic unused_irq_clr;
  assign unused_irq_clr = |irq_clr;
  assign irq_d = to_fire;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_q      <= '0;
      write_q     <= '0;
      pend_q      <= '0;
      irq_q       <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        age_q[i] <= '0;
        op_q[i]  <= OP_RD;
      end
    end else begin
      read_q      <= read;
      write_q     <= write;
      pend_q      <= pend_d;
      irq_q       <= irq_d;
      proto_err_q <= proto_err_d;
      for (int i = 0; i < NCH; i++) begin
        age_q[i] <= age_d[i];
        op_q[i]  <= op_d[i];
      end
    end
  end

  // Outside IDLE the offered channel is the only request, so an accept advances past it.
  assign arb_req = (state_q == IDLE) ? (pend_q & ~to_hit) : cur_oh;
  assign arb_adv = (state_q == ISSUE) && op_ready && !to_hit[ch_q];

  rw_sched_rr_arb #(.NCH(NCH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (arb_req),
    .adv_i     (arb_adv),
    .gnt_idx_o (arb_idx),
    .gnt_any_o (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      op_valid_q  <= 1'b0;
      op_write_q  <= 1'b0;
      op_abort_q  <= 1'b0;
      rd_served_q <= '0;
      wr_served_q <= '0;
    end else begin
      op_abort_q  <= 1'b0;
      rd_served_q <= '0;
      wr_served_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q    <= ISSUE;
            ch_q       <= arb_idx;
            op_valid_q <= 1'b1;
            op_write_q <= (op_q[arb_idx] == OP_WR);
          end
        end
        ISSUE: begin
          if (to_hit[ch_q]) begin
            state_q    <= IDLE;
            op_valid_q <= 1'b0;
            op_abort_q <= 1'b1;
            ch_q       <= '0;
            op_write_q <= 1'b0;
          end else if (op_ready) begin
            state_q    <= WAIT;
            op_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (op_done) begin
            if (op_write_q) wr_served_q <= cur_oh;
            else            rd_served_q <= cur_oh;
            state_q    <= IDLE;
            ch_q       <= '0;
            op_write_q <= 1'b0;
          end else if (to_hit[ch_q]) begin
            state_q    <= IDLE;
            op_abort_q <= 1'b1;
            ch_q       <= '0;
            op_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_served = rd_served_q;
  assign wr_served = wr_served_q;
  assign interrupt = irq_q;
  assign proto_err = proto_err_q;
  assign op_valid  = op_valid_q;
  assign op_write  = op_write_q;
  assign op_ch     = ch_q;
  assign op_abort  = op_abort_q;

endmodule

// File: tb/tb_rw_sched.sv
// Directed, table-driven bench for rw_sched (NCH=4, MAX_LAT=5) plus reset and sticky-irq sequences.
module tb_rw_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] read, write, irq_clr;
  logic [3:0] rd_served, wr_served, interrupt;
  logic       proto_err, op_valid, op_ready, op_write, op_done, op_abort;
  logic [1:0] op_ch;

  int errors = 0;
  int checks = 0;

  rw_sched #(.NCH(4), .MAX_LAT(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .write     (write),
    .rd_served (rd_served),
    .wr_served (wr_served),
    .interrupt (interrupt),
    .irq_clr   (irq_clr),
    .proto_err (proto_err),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_write  (op_write),
    .op_ch     (op_ch),
    .op_done   (op_done),
    .op_abort  (op_abort)
  );

  always #5 clk = ~clk;

`ifdef RW_SCHED_STICKY_IRQ_EN
  localparam logic [3:0] HOLD_IRQ = 4'b1000;
`else
  localparam logic [3:0] HOLD_IRQ = 4'b0000;
`endif

  // Output vector layout: {rd_served, wr_served, interrupt, proto_err, op_valid, op_write, op_ch, op_abort}
  localparam logic [17:0] Z = 18'h0;

  typedef struct {
    string       name;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [3:0]  clr;
    logic        rdy;
    logic        done;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] ex(input logic [3:0] rs, input logic [3:0] ws,
                                     input logic [3:0] irq, input logic perr, input logic v,
                                     input logic w, input logic [1:0] ch, input logic ab);
    return {rs, ws, irq, perr, v, w, ch, ab};
  endfunction

  function automatic logic [17:0] outs();
    return {rd_served, wr_served, interrupt, proto_err, op_valid, op_write, op_ch, op_abort};
  endfunction

  task automatic add(input string nm, input logic [3:0] rd, input logic [3:0] wr,
                     input logic rdy, input logic done, input logic [17:0] e);
    vec_t v;
    v.name = nm;
    v.rd   = rd;
    v.wr   = wr;
    v.clr  = 4'hF;
    v.rdy  = rdy;
    v.done = done;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // two write captures and a read together: ch0 served, ch1/ch3 time out together
    add("t2_cap",    4'b1000, 4'b0011, 1, 1, Z);
    add("t2_issue0", 4'b1000, 4'b0011, 1, 1, ex(0, 0, 0, 0, 1, 1, 0, 0));
    add("t2_acc0",   4'b1000, 4'b0011, 1, 1, ex(0, 0, 0, 0, 0, 1, 0, 0));
    add("t2_srv0",   4'b1000, 4'b0011, 1, 1, ex(0, 4'b0001, 0, 0, 0, 0, 0, 0));
    add("t2_to13",   4'b1000, 4'b0011, 1, 1, ex(0, 0, 4'b1010, 0, 0, 0, 0, 0));
    add("t2_quiet",  4'b0000, 4'b0000, 1, 1, Z);
    // minimum latency read on ch2
    add("t1_cap",    4'b0100, 4'b0000, 1, 1, Z);
    add("t1_issue",  4'b0100, 4'b0000, 1, 1, ex(0, 0, 0, 0, 1, 0, 2, 0));
    add("t1_acc",    4'b0100, 4'b0000, 1, 1, ex(0, 0, 0, 0, 0, 0, 2, 0));
    add("t1_srv",    4'b0100, 4'b0000, 1, 1, ex(4'b0100, 0, 0, 0, 0, 0, 0, 0));
    add("t1_quiet",  4'b0000, 4'b0000, 1, 1, Z);
    // server never ready: abort at capture+4, then op_done during abort cycle ignored
    add("t3_cap",    4'b0010, 4'b0000, 0, 0, Z);
    add("t3_offer1", 4'b0010, 4'b0000, 0, 0, ex(0, 0, 0, 0, 1, 0, 1, 0));
    add("t3_offer2", 4'b0010, 4'b0000, 0, 0, ex(0, 0, 0, 0, 1, 0, 1, 0));
    add("t3_offer3", 4'b0010, 4'b0000, 0, 0, ex(0, 0, 0, 0, 1, 0, 1, 0));
    add("t3_timeout",4'b0010, 4'b0000, 0, 0, ex(0, 0, 4'b0010, 0, 0, 0, 0, 1));
    add("t3_doneign",4'b0000, 4'b0000, 0, 1, Z);
    // read and write together on ch0
    add("t4_both",   4'b0001, 4'b0001, 0, 0, ex(0, 0, 0, 1, 0, 0, 0, 0));
    add("t4_hold",   4'b0001, 4'b0001, 0, 0, ex(0, 0, 0, 1, 0, 0, 0, 0));
    add("t4_rel",    4'b0000, 4'b0000, 0, 0, Z);
    add("t4_idle",   4'b0000, 4'b0000, 0, 0, Z);
    // re-rise while pending is dropped with proto_err; original deadline unchanged
    add("rp_cap",    4'b0001, 4'b0000, 0, 0, Z);
    add("rp_offer",  4'b0001, 4'b0000, 0, 0, ex(0, 0, 0, 0, 1, 0, 0, 0));
    add("rp_drop",   4'b0000, 4'b0000, 0, 0, ex(0, 0, 0, 0, 1, 0, 0, 0));
    add("rp_rerise", 4'b0001, 4'b0000, 0, 0, ex(0, 0, 0, 1, 1, 0, 0, 0));
    add("rp_timeout",4'b0001, 4'b0000, 0, 0, ex(0, 0, 4'b0001, 0, 0, 0, 0, 1));
    add("rp_quiet",  4'b0000, 4'b0000, 0, 0, Z);
    // op_done lands in the deadline cycle of ch2: served wins
    add("t5_cap",    4'b0000, 4'b0100, 0, 0, Z);
    add("t5_issue",  4'b0000, 4'b0100, 1, 0, ex(0, 0, 0, 0, 1, 1, 2, 0));
    add("t5_acc",    4'b0000, 4'b0100, 1, 0, ex(0, 0, 0, 0, 0, 1, 2, 0));
    add("t5_wait",   4'b0000, 4'b0100, 0, 0, ex(0, 0, 0, 0, 0, 1, 2, 0));
    add("t5_donedl", 4'b0000, 4'b0100, 0, 1, ex(0, 4'b0100, 0, 0, 0, 0, 0, 0));
    add("t5_quiet",  4'b0000, 4'b0000, 0, 0, Z);
    // pointer sits at 3 here, so ch3 beats the lower-numbered ch2
    add("rr_cap",    4'b1100, 4'b0000, 1, 1, Z);
    add("rr_issue3", 4'b1100, 4'b0000, 1, 1, ex(0, 0, 0, 0, 1, 0, 3, 0));
    add("rr_acc3",   4'b1100, 4'b0000, 1, 1, ex(0, 0, 0, 0, 0, 0, 3, 0));
    add("rr_srv3",   4'b1100, 4'b0000, 1, 1, ex(4'b1000, 0, 0, 0, 0, 0, 0, 0));
    add("rr_to2",    4'b1100, 4'b0000, 1, 1, ex(0, 0, 4'b0100, 0, 0, 0, 0, 0));
    add("rr_quiet",  4'b0000, 4'b0000, 1, 1, Z);

    rst      = 1'b1;
    read     = '0;
    write    = '0;
    irq_clr  = '0;
    op_ready = 1'b0;
    op_done  = 1'b0;
    tick();
    check("reset_outs", outs(), Z);
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_outs", outs(), Z);

    foreach (vecs[k]) begin
      read     = vecs[k].rd;
      write    = vecs[k].wr;
      irq_clr  = vecs[k].clr;
      op_ready = vecs[k].rdy;
      op_done  = vecs[k].done;
      tick();
      check(vecs[k].name, outs(), vecs[k].exp);
    end

    // reset asserted while a write on ch1 is in flight
    read     = '0;
    write    = 4'b0010;
    op_ready = 1'b1;
    op_done  = 1'b0;
    irq_clr  = 4'hF;
    tick();
    tick();
    tick();
    check("rw_wait", outs(), ex(0, 0, 0, 0, 0, 1, 1, 0));
    #2;
    rst   = 1'b1;
    write = '0;
    #1;
    check("rw_async_rst", outs(), Z);
    op_done = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("rw_after_rst", outs(), Z);
    end

    // timeout on ch3 with irq_clr low; sticky builds hold the bit until cleared
    op_ready = 1'b0;
    op_done  = 1'b0;
    irq_clr  = '0;
    read     = 4'b1000;
    for (int n = 0; n < 5; n++) tick();
    check("st_timeout", outs(), ex(0, 0, 4'b1000, 0, 0, 0, 0, 1));
    read = '0;
    for (int n = 0; n < 10; n++) begin
      tick();
      check("st_hold", outs(), ex(0, 0, HOLD_IRQ, 0, 0, 0, 0, 0));
    end
    irq_clr = 4'b1000;
    tick();
    check("st_clr", outs(), Z);
    irq_clr = '0;
    tick();
    check("st_after_clr", outs(), Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rw_sched.md
# rw_sched

Multi-channel read/write request scheduler with a bounded-latency guarantee. Captures read/write request edges from `NCH` channels and issues one operation at a time, round-robin, to a shared downstream server. For every captured request it signals served or interrupt within `MAX_LAT` cycles. Sits between the requesting clients and the memory/service port.

## Interface

**Parameters**
- `NCH`, 4: number of request channels (≥2).
- `MAX_LAT`, 5: deadline in cycles from capture to served/interrupt (≥2).
- `CHW`, `$clog2(NCH)`: channel index width (derived).
- `AGEW`, `$clog2(MAX_LAT+1)`: age counter width (derived).

**Ports**

Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.

Client side:
- `read` in NCH: per-channel read request level.
- `write` in NCH: per-channel write request level.
- `rd_served` out NCH: one-cycle pulse, read completed for that channel.
- `wr_served` out NCH: one-cycle pulse, write completed for that channel.
- `interrupt` out NCH: deadline miss for that channel (pulse or sticky, see Configuration).
- `irq_clr` in NCH: clears sticky interrupt bits; ignored when the sticky feature is compiled out.
- `proto_err` out 1: one-cycle pulse on a client protocol violation.

Server side:
- `op_valid` out 1: operation offered.
- `op_ready` in 1: server accepts the offered operation.
- `op_write` out 1: 1 = write, 0 = read.
- `op_ch` out CHW: channel of the offered operation.
- `op_done` in 1: in-flight operation complete.
- `op_abort` out 1: one-cycle pulse; the in-flight operation is cancelled.

## Operation

**Capture**
- A rising edge of `read[i]` or `write[i]` sets `pend[i]`, latches the operation type, and clears `age[i]` to 0.
- Simultaneous rise of `read[i]` and `write[i]`, or `read[i] && write[i]` high in any cycle: nothing is captured for `i`, and `proto_err` pulses.
- A rise on channel `i` while `pend[i]` is set is dropped, and `proto_err` pulses.

**Ageing**
- `age[i]` increments every cycle while `pend[i]` is set.

**Arbitration**
- Round-robin over pending channels that are not in flight.
- The priority pointer starts at channel 0 after reset.
- The pointer moves to one past the granted channel on each `op_ready` acceptance.

**State machine**
- IDLE: if any pending channel is eligible, select the arbiter winner and go to ISSUE.
- ISSUE: `op_valid`=1 with `op_write`/`op_ch` stable. On `op_ready`, go to WAIT.
- WAIT: on `op_done`, pulse `rd_served[ch]` or `wr_served[ch]` and clear `pend[ch]`, then go to IDLE.

**Deadline**
- If `age[i]` reaches `MAX_LAT`-1 and no completion for `i` is sampled in the same cycle, the following happens at that edge:
  - `pend[i]` clears;
  - `interrupt[i]` asserts;
  - if `i` is the offered or in-flight channel, `op_abort` pulses and the FSM returns to IDLE.
- Net guarantee: served or interrupt occurs 1..`MAX_LAT` cycles after capture.

**Simultaneous events**
- `op_done` and deadline in the same cycle for the same channel: served wins, no interrupt.
- Multiple channels may time out in the same cycle; their interrupts assert together.
- `rd_served`, `wr_served`, and `interrupt` are never high for the same channel in the same cycle.

## Timing

- All outputs are registered.
- Reset values: all outputs 0; all `pend`/`age` 0; FSM in IDLE; pointer at channel 0.
- Reset asserted mid-operation discards all pending work with no abort pulse.
- Minimum latency with the server ready immediately and `op_done` returned the cycle after accept:
  - capture edge t0;
  - `op_valid` from t0+1;
  - accept at t0+1;
  - served pulse at t0+3.
- `op_valid` is held until `op_ready`, unless aborted; `op_write`/`op_ch` do not change while `op_valid`=1.
- `op_done` outside WAIT is ignored.
- `op_done` in the cycle of `op_abort` is ignored.

## Configuration

Macro: `RW_SCHED_STICKY_IRQ_EN`.
- Defined: `interrupt[i]` stays high until `irq_clr[i]` is sampled high. If set and clear occur in the same cycle, set wins.
- Undefined: `interrupt[i]` is a one-cycle pulse, and `irq_clr` is unused.

## Structure

- Package `rw_sched_pkg` holds:
  - the FSM state enum (`IDLE`, `ISSUE`, `WAIT`);
  - the op-type typedef (`OP_RD`, `OP_WR`).
- Sub-module `rw_sched_rr_arb`: parametrised `NCH`-way round-robin arbiter.
  - Inputs: request vector, pointer-advance strobe.
  - Outputs: grant index, any-grant.

## Test plan

1. `NCH`=4, `MAX_LAT`=5. Rise `read[2]`; `op_ready` and `op_done` return immediately. Expect `op_ch`=2, `op_write`=0, and `rd_served[2]` pulse 3 cycles after capture, with no interrupt.
2. `write[0]`, `write[1]`, `read[3]` rise together; server is always ready. Expect issue order 0, 1, 3, and each served within 5 cycles or interrupted.
3. Rise `read[1]` and hold `op_ready`=0. Expect `interrupt[1]` at capture+4, `op_abort` pulse, FSM back to IDLE, and no `rd_served[1]`.
4. `read[0]` and `write[0]` both rise in one cycle. Expect a `proto_err` pulse, nothing issued, all outputs 0.
5. `op_done` for channel 2 arrives in the deadline cycle. Expect `wr_served[2]` only, with no interrupt.
6. Sticky build: a timeout sets `interrupt[3]`, which holds for 10 cycles; `irq_clr[3]` clears it the next cycle. Assert reset during WAIT: all outputs go to 0 immediately.
